// File: rtl/cast_output_stage.sv
`default_nettype none

`ifndef CAST_ROUTER_BUFFER_DEPTH_LOG
`define CAST_ROUTER_BUFFER_DEPTH_LOG 4
`endif
`ifndef DW
`define DW 34
`endif

// ============================================================================
// Module   : cast_output_stage
// Brief    : Cast router output port: 2-entry skid buffer, credit-based
//            downstream flow control and output-VC busy tracking.
// Revision : 1.0 - initial release
// ============================================================================
module cast_output_stage #(
    parameter int x_pos   = 0,
    parameter int y_pos   = 0,
    parameter int CREDITS = 2 ** `CAST_ROUTER_BUFFER_DEPTH_LOG,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           valid_i,
    input  logic [`DW-1:0] data_i,
    output logic           ready_o,
    output logic           valid_o,
    output logic [`DW-1:0] data_o,
    input  logic           ready_i,
    input  logic           credit_i,
    input  logic           vc_alloc_i,
    output logic           vc_free_o,
    output logic [CW-1:0]  credit_cnt_o
);

    localparam logic [CW-1:0] c_cnt_max = CW'(CREDITS);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);

    typedef enum logic [0:0] {
        VC_FREE = 1'b0,
        VC_BUSY = 1'b1
    } vc_state_t;

    vc_state_t      r_vc_state;
    vc_state_t      w_vc_state_next;

    logic           r_v0;
    logic           r_v1;
    logic [`DW-1:0] r_d0;
    logic [`DW-1:0] r_d1;
    logic           r_ready;
    logic [CW-1:0]  r_cnt;

    logic           w_v0_next;
    logic           w_v1_next;
    logic [`DW-1:0] w_d0_next;
    logic [`DW-1:0] w_d1_next;
    logic [CW-1:0]  w_cnt_next;

    logic           w_fire;
    logic           w_accept;
    logic           w_tail_fire;
    logic           w_head_in;

    assign valid_o      = r_v0 && (r_cnt != '0);
    assign data_o       = r_d0;
    assign ready_o      = r_ready;
    assign credit_cnt_o = r_cnt;

    assign w_fire      = valid_o && ready_i;
    assign w_accept    = valid_i && r_ready;
    // Tail (10) and single (11) both have the upper type bit set.
    assign w_tail_fire = w_fire && r_d0[`DW-1];
    assign w_head_in   = w_accept && (data_i[`DW-1] == data_i[`DW-2]);

    // ready_o only rises when entry1 is empty, so an accepted flit never sees a full buffer.
    always_comb begin
        w_v0_next = r_v0;
        w_v1_next = r_v1;
        w_d0_next = r_d0;
        w_d1_next = r_d1;
        if (w_fire) begin
            if (r_v1) begin
                w_d0_next = r_d1;
                w_v1_next = 1'b0;
            end else if (w_accept) begin
                w_d0_next = data_i;
            end else begin
                w_v0_next = 1'b0;
            end
        end else if (w_accept) begin
            if (!r_v0) begin
                w_v0_next = 1'b1;
                w_d0_next = data_i;
            end else begin
                w_v1_next = 1'b1;
                w_d1_next = data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_d0    <= '0;
            r_d1    <= '0;
            r_ready <= 1'b0;
        end else begin
            r_v0    <= w_v0_next;
            r_v1    <= w_v1_next;
            r_d0    <= w_d0_next;
            r_d1    <= w_d1_next;
            r_ready <= !w_v1_next;
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_fire && !credit_i) begin
            w_cnt_next = r_cnt - c_cnt_one;
        end else if (!w_fire && credit_i && (r_cnt != c_cnt_max)) begin
            w_cnt_next = r_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= c_cnt_max;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vc_state <= VC_FREE;
        end else begin
            r_vc_state <= w_vc_state_next;
        end
    end

    // A new grant coinciding with the tail leaving keeps the VC busy for the next packet.
    always_comb begin
        w_vc_state_next = r_vc_state;
        vc_free_o       = 1'b0;
        case (r_vc_state)
            VC_FREE: begin
                vc_free_o = 1'b1;
                if (vc_alloc_i) begin
                    w_vc_state_next = VC_BUSY;
                end
            end
            VC_BUSY: begin
                if (w_tail_fire && !vc_alloc_i) begin
                    w_vc_state_next = VC_FREE;
                end
            end
            default: begin
                w_vc_state_next = VC_FREE;
            end
        endcase
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstn) begin
            assert (!(credit_i && !w_fire && (r_cnt == c_cnt_max)))
                else $error("cast_output_stage(%0d,%0d): credit returned with counter full", x_pos, y_pos);
            assert (!(vc_alloc_i && (r_vc_state == VC_BUSY) && !w_tail_fire))
                else $error("cast_output_stage(%0d,%0d): VC granted while busy", x_pos, y_pos);
            assert (!(w_head_in && (r_vc_state == VC_FREE) && !vc_alloc_i))
                else $error("cast_output_stage(%0d,%0d): head flit on unallocated VC", x_pos, y_pos);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cast_output_stage.sv
`default_nettype none

`ifndef CAST_ROUTER_BUFFER_DEPTH_LOG
`define CAST_ROUTER_BUFFER_DEPTH_LOG 4
`endif
`ifndef DW
`define DW 34
`endif

// ============================================================================
// Module   : tb_cast_output_stage
// Brief    : Self-checking bench for cast_output_stage against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cast_output_stage;

    localparam int DW       = `DW;
    localparam int CREDITS  = 2 ** `CAST_ROUTER_BUFFER_DEPTH_LOG;
    localparam int CW       = $clog2(CREDITS + 1);
    localparam int CREDITS4 = 4;
    localparam int CW4      = $clog2(CREDITS4 + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic          valid_i, ready_o, valid_o, ready_i, credit_i, vc_alloc_i, vc_free_o;
    logic [DW-1:0] data_i, data_o;
    logic [CW-1:0] credit_cnt_o;

    logic           v4_i, ready4_o, valid4_o, r4_i, c4_i, a4_i, free4_o;
    logic [DW-1:0]  d4_i, data4_o;
    logic [CW4-1:0] cnt4_o;

    always #5 clk = ~clk;

    cast_output_stage u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .ready_i      (ready_i),
        .credit_i     (credit_i),
        .vc_alloc_i   (vc_alloc_i),
        .vc_free_o    (vc_free_o),
        .credit_cnt_o (credit_cnt_o)
    );

    cast_output_stage #(.CREDITS(CREDITS4)) u_dut4 (
        .clk          (clk),
        .rstn         (rstn),
        .valid_i      (v4_i),
        .data_i       (d4_i),
        .ready_o      (ready4_o),
        .valid_o      (valid4_o),
        .data_o       (data4_o),
        .ready_i      (r4_i),
        .credit_i     (c4_i),
        .vc_alloc_i   (a4_i),
        .vc_free_o    (free4_o),
        .credit_cnt_o (cnt4_o)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] m_q[$];
    int            m_cnt;
    bit            m_busy;
    bit            m_rdy;
    bit            toggle = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_err++;
        $error("FAIL %s: observed no progress, required progress within bound", tag);
    endtask

    function automatic logic [DW-1:0] flit(input logic [1:0] t);
        logic [DW-3:0] p;
        p = $urandom;
        return {t, p};
    endfunction

    function automatic bit f_fire(input bit rdy);
        return (m_q.size() > 0) && (m_cnt > 0) && rdy;
    endfunction

    function automatic bit f_tail(input bit rdy);
        return f_fire(rdy) && m_q[0][DW-1];
    endfunction

    function automatic bit pick_rdy(input int rmode);
        if (rmode == 0) return 1'b1;
        if (rmode == 1) begin
            toggle = ~toggle;
            return toggle;
        end
        return 1'($urandom_range(0, 1));
    endfunction

    // 0 none, 1 random while below full, 2 exactly when a flit leaves, 3 always while below full
    function automatic bit pick_cred(input int cmode, input bit rdy);
        case (cmode)
            1: return (m_cnt < CREDITS) && ($urandom_range(0, 1) == 1);
            2: return f_fire(rdy);
            3: return (m_cnt < CREDITS);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cnt  = CREDITS;
        m_busy = 1'b0;
        m_rdy  = 1'b0;
    endtask

    // Entered at posedge+1; checks at the falling edge, returns at the next posedge+1.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit rdy, input bit cred,
                         input bit alloc, output bit acc);
        bit fire, tail;
        valid_i = v; data_i = d; ready_i = rdy; credit_i = cred; vc_alloc_i = alloc;
        #4;
        fire = f_fire(rdy);
        tail = f_tail(rdy);
        chk("valid_o", valid_o, (m_q.size() > 0) && (m_cnt > 0));
        chk("ready_o", ready_o, m_rdy);
        chk("vc_free_o", vc_free_o, !m_busy);
        chk("credit_cnt_o", credit_cnt_o, m_cnt);
        if (m_q.size() > 0) chk("data_o", data_o, m_q[0]);
        acc = v && m_rdy;
        @(posedge clk); #1;
        if (fire) void'(m_q.pop_front());
        if (acc) m_q.push_back(d);
        m_cnt = m_cnt - int'(fire) + int'(cred);
        if (m_cnt > CREDITS) m_cnt = CREDITS;
        if (alloc) m_busy = 1'b1;
        else if (tail) m_busy = 1'b0;
        m_rdy = (m_q.size() < 2);
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input int rmode, input int cmode,
                        input bit alloc_tail, output bit acc);
        bit rdy, cred, alloc;
        rdy   = pick_rdy(rmode);
        cred  = pick_cred(cmode, rdy);
        alloc = alloc_tail && f_tail(rdy);
        cycle(v, d, rdy, cred, alloc, acc);
    endtask

    task automatic send_packet(input int len, input int rmode, input int cmode,
                               input bit need_alloc, input bit alloc_tail);
        bit acc, rdy;
        int guard;
        logic [1:0] t;
        logic [DW-1:0] f;
        if (need_alloc) begin
            guard = 0;
            while (m_busy && guard < 200) begin
                step(1'b0, '0, rmode, cmode, 1'b0, acc);
                guard++;
            end
            if (m_busy) timeout("vc_wait");
            rdy = pick_rdy(rmode);
            cycle(1'b0, '0, rdy, pick_cred(cmode, rdy), 1'b1, acc);
        end
        for (int i = 0; i < len; i++) begin
            if (len == 1) t = 2'b11;
            else if (i == 0) t = 2'b00;
            else if (i == len - 1) t = 2'b10;
            else t = 2'b01;
            f = flit(t);
            guard = 0;
            do begin
                step(1'b1, f, rmode, cmode, alloc_tail, acc);
                guard++;
            end while (!acc && guard < 100);
            if (!acc) timeout("accept");
        end
    endtask

    task automatic drain(input int rmode, input int cmode, input bit alloc_tail);
        bit acc;
        int guard = 0;
        while (m_q.size() > 0 && guard < 300) begin
            step(1'b0, '0, rmode, cmode, alloc_tail, acc);
            guard++;
        end
        if (m_q.size() > 0) timeout("drain");
        guard = 0;
        while (m_cnt < CREDITS && guard < 100) begin
            step(1'b0, '0, 0, 3, 1'b0, acc);
            guard++;
        end
    endtask

    initial begin
        logic [DW-1:0] f4[6];
        logic [DW-1:0] fired[6];
        int  idx, nfire, guard, i;
        bit  acc, took;

        rstn = 1'b1;
        valid_i = 0; data_i = '0; ready_i = 0; credit_i = 0; vc_alloc_i = 0;
        v4_i = 0; d4_i = '0; r4_i = 0; c4_i = 0; a4_i = 0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_ready_o", ready_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_credit_cnt", credit_cnt_o, CREDITS);
        chk("rst_vc_free", vc_free_o, 1);
        chk("rst4_credit_cnt", cnt4_o, CREDITS4);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();

        // Single flit: alloc, accept, visible next cycle, credit 16->15, VC freed after fire
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b1, {2'b11, 32'h0000_005A}, 1'b1, 1'b0, 1'b0, acc);
        chk("t1_accepted", acc, 1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        chk("t1_cnt_after_fire", credit_cnt_o, CREDITS - 1);
        chk("t1_vc_free_after_fire", vc_free_o, 1);
        drain(0, 3, 1'b0);
        valid_i = 0; ready_i = 0; credit_i = 0; vc_alloc_i = 0;

        // Four-credit instance: 6-flit packet stalls after 4 fires until a credit returns
        f4[0] = flit(2'b00);
        for (int k = 1; k < 5; k++) f4[k] = flit(2'b01);
        f4[5] = flit(2'b10);
        idx = 0; nfire = 0; r4_i = 1'b1; c4_i = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            v4_i = (idx < 6);
            d4_i = f4[(idx < 6) ? idx : 5];
            a4_i = (cyc == 0);
            #4;
            took = v4_i && ready4_o;
            if (valid4_o) begin
                if (nfire < 6) fired[nfire] = data4_o;
                nfire++;
            end
            @(posedge clk); #1;
            if (took) idx++;
        end
        v4_i = 1'b0; a4_i = 1'b0;
        chk("t2_fire_count", nfire, 4);
        for (int k = 0; k < 4; k++) chk("t2_fire_order", fired[k], f4[k]);
        chk("t2_all_accepted", idx, 6);
        chk("t2_valid_stalled", valid4_o, 0);
        chk("t2_ready_full", ready4_o, 0);
        chk("t2_cnt_zero", cnt4_o, 0);
        c4_i = 1'b1;
        @(posedge clk); #1;
        c4_i = 1'b0;
        #3;
        chk("t2_valid_after_credit", valid4_o, 1);
        chk("t2_data_fifth", data4_o, f4[4]);
        chk("t2_cnt_one", cnt4_o, 1);
        @(posedge clk); #4;
        chk("t2_valid_after_fifth", valid4_o, 0);
        chk("t2_data_sixth", data4_o, f4[5]);
        chk("t2_ready_reopened", ready4_o, 1);
        @(posedge clk); #1;

        // 8-flit packet with ready_i toggling every cycle
        send_packet(8, 1, 1, 1'b1, 1'b0);
        drain(1, 1, 1'b0);

        // Simultaneous fire and credit keep the counter constant
        send_packet(12, 0, 2, 1'b1, 1'b0);
        chk("t4_cnt_const", credit_cnt_o, CREDITS);
        drain(0, 2, 1'b0);

        // Tail fire coincident with a new grant keeps the VC busy for the next packet
        send_packet(3, 0, 2, 1'b1, 1'b1);
        drain(0, 2, 1'b1);
        chk("t5_vc_still_busy", vc_free_o, 0);
        send_packet(4, 0, 2, 1'b0, 1'b0);
        drain(0, 2, 1'b0);
        chk("t5_vc_freed", vc_free_o, 1);

        // Randomized packet traffic
        for (int p = 0; p < 25; p++) begin
            send_packet($urandom_range(1, 6), 2, 1, 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) drain(2, 1, 1'b0);
        end
        drain(2, 1, 1'b0);

        // Mid-packet reset with 2 flits buffered and 3 credits left
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
        i = 0; guard = 0;
        while (!(m_q.size() == 2 && m_cnt == 3) && guard < 100) begin
            cycle(1'b1, flit((i == 0) ? 2'b00 : 2'b01), (m_cnt > 3), 1'b0, 1'b0, acc);
            if (acc) i++;
            guard++;
        end
        if (!(m_q.size() == 2 && m_cnt == 3)) timeout("t6_setup");
        chk("t6_cnt_before", credit_cnt_o, 3);
        chk("t6_valid_before", valid_o, 1);
        valid_i = 1'b0; ready_i = 1'b0;
        rstn = 1'b0;
        #1;
        chk("t6_valid_in_reset", valid_o, 0);
        chk("t6_ready_in_reset", ready_o, 0);
        chk("t6_cnt_in_reset", credit_cnt_o, CREDITS);
        chk("t6_vc_free_in_reset", vc_free_o, 1);
        chk("t6_data_in_reset", data_o, 0);
        rstn = 1'b1;
        model_reset();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        send_packet(5, 2, 1, 1'b1, 1'b0);
        drain(2, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
